// File: rtl/pc_mux_pkg.sv
// Shared constants, state encoding and helpers for the next-PC selector.
package pc_mux_pkg;

  localparam int unsigned SRC_SEQ    = 0;
  localparam int unsigned SRC_BRANCH = 1;
  localparam int unsigned SRC_JUMP   = 2;
  localparam int unsigned SRC_TRAP   = 3;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Select-field width for an n-way mux; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nxone_mux.sv
// Combinational N:1 mux; an out-of-range select returns source DEFAULT_IDX.
module nxone_mux
  import pc_mux_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned DEFAULT_IDX = 0
)(
  input  logic [NUM_SRC*XLEN-1:0]       data,
  input  logic [sel_width(NUM_SRC)-1:0] sel,
  output logic [XLEN-1:0]               y
);

  localparam int unsigned SEL_W = sel_width(NUM_SRC);

  always_comb begin
    y = data[DEFAULT_IDX*XLEN +: XLEN];
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) y = data[i*XLEN +: XLEN];
    end
  end

endmodule

// File: rtl/pc_redirect_mux.sv
// Registered next-PC selector with redirect capture while fetch stalls.
// Optional PC_ALIGN_CHECK_EN: clears PC bits [1:0] on load and flags misalign.
module pc_redirect_mux
  import pc_mux_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     NUM_SRC   = 4,
  parameter int unsigned     SEQ_SRC   = SRC_SEQ,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000)
)(
  input  logic                          clk,
  input  logic                          Reset,
  input  logic [NUM_SRC*XLEN-1:0]       src_data,
  input  logic [sel_width(NUM_SRC)-1:0] src_sel,
  input  logic                          redirect_valid,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [XLEN-1:0]               out_pc,
  output logic                          pending
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                          misalign
`endif
);

  localparam int unsigned SEL_W = sel_width(NUM_SRC);

  state_t          state, state_nxt;
  logic [XLEN-1:0] held, held_nxt;
  logic [XLEN-1:0] live_pc, seq_pc, load_val, load_pc;
  logic            load;

  nxone_mux #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEFAULT_IDX(SEQ_SRC)) u_live_mux (
    .data (src_data),
    .sel  (src_sel),
    .y    (live_pc)
  );

  nxone_mux #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEFAULT_IDX(SEQ_SRC)) u_seq_mux (
    .data (src_data),
    .sel  (SEL_W'(SEQ_SRC)),
    .y    (seq_pc)
  );

  // Next state, held-redirect update and load selection.
  always_comb begin
    state_nxt = state;
    held_nxt  = held;
    load      = 1'b0;
    load_val  = seq_pc;
    case (state)
      BOOT: begin
        if (redirect_valid) begin
          held_nxt  = live_pc;
          state_nxt = HOLD;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        if (out_valid && out_ready) begin
          load      = 1'b1;
          state_nxt = RUN;
          held_nxt  = '0;
          if (redirect_valid)     load_val = live_pc;
          else if (state == HOLD) load_val = held;
          else                    load_val = seq_pc;
        end else if (redirect_valid) begin
          held_nxt  = live_pc;
          state_nxt = HOLD;
        end
      end
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  assign load_pc = {load_val[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (Reset)     misalign <= 1'b0;
    else if (load) misalign <= |load_val[1:0];
  end
`else
  assign load_pc = load_val;
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= BOOT;
      held      <= '0;
      out_pc    <= RESET_VEC;
      out_valid <= 1'b0;
      pending   <= 1'b0;
    end else begin
      state     <= state_nxt;
      held      <= held_nxt;
      out_valid <= (state_nxt != BOOT);
      pending   <= (state_nxt == HOLD);
      if (load) out_pc <= load_pc;
    end
  end

endmodule

// File: tb/tb_pc_redirect_mux.sv
// Directed self-checking bench for pc_redirect_mux (default and PC_ALIGN_CHECK_EN builds).
module tb_pc_redirect_mux;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_SRC = 4;

  logic                    clk;
  logic                    Reset;
  logic [XLEN-1:0]         src [NUM_SRC];
  logic [NUM_SRC*XLEN-1:0] src_data;
  logic [1:0]              src_sel;
  logic                    redirect_valid;
  logic                    out_ready;
  logic                    out_valid;
  logic [XLEN-1:0]         out_pc;
  logic                    pending;
`ifdef PC_ALIGN_CHECK_EN
  logic                    misalign;
`endif

  int errors = 0;
  int checks = 0;

  assign src_data = {src[3], src[2], src[1], src[0]};

  pc_redirect_mux #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEQ_SRC(0), .RESET_VEC(32'h0000_0000)) dut (
    .clk            (clk),
    .Reset          (Reset),
    .src_data       (src_data),
    .src_sel        (src_sel),
    .redirect_valid (redirect_valid),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .pending        (pending)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign       (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic p);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, ".pc"}, out_pc, pc);
    check({tag, ".pending"}, {31'd0, pending}, {31'd0, p});
  endtask

  initial begin
    logic [31:0] exp_align;
    Reset = 1'b1;
    redirect_valid = 1'b1;
    src_sel = 2'd1;
    out_ready = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) src[i] = 32'h0;
    src[1] = 32'h0000_0DEC;

    // Reset dominates a simultaneous redirect.
    step();
    step();
    chk_out("reset", 1'b0, 32'h0, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
    check("reset.misalign", {31'd0, misalign}, 32'd0);
`endif

    Reset = 1'b0;
    redirect_valid = 1'b0;
    src[0] = 32'h4;
    step();
    chk_out("boot_exit", 1'b1, 32'h0, 1'b0);

    // Sequential stream at one PC per cycle.
    step();
    chk_out("seq4", 1'b1, 32'h4, 1'b0);
    src[0] = 32'h8;
    step();
    chk_out("seq8", 1'b1, 32'h8, 1'b0);
    src[0] = 32'hC;
    step();
    chk_out("seqC", 1'b1, 32'hC, 1'b0);

    // Redirect while stalled is captured and delivered on release.
    src[0] = 32'h10;
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    src_sel = 2'd1;
    src[1] = 32'h100;
    step();
    chk_out("stall_cap", 1'b1, 32'hC, 1'b1);
    redirect_valid = 1'b0;
    src[1] = 32'h999;
    step();
    chk_out("stall_hold", 1'b1, 32'hC, 1'b1);
    out_ready = 1'b1;
    step();
    chk_out("release", 1'b1, 32'h100, 1'b0);
    src[0] = 32'h104;
    step();
    chk_out("after_rel", 1'b1, 32'h104, 1'b0);

    // Newest captured redirect wins.
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    src_sel = 2'd1;
    src[1] = 32'h100;
    step();
    src_sel = 2'd3;
    src[3] = 32'h200;
    step();
    chk_out("newest_hold", 1'b1, 32'h104, 1'b1);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk_out("newest", 1'b1, 32'h200, 1'b0);

    // Live redirect beats a held one during transfer; held value discarded.
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    src_sel = 2'd1;
    src[1] = 32'h100;
    step();
    check("held_set.pending", {31'd0, pending}, 32'd1);
    src_sel = 2'd2;
    src[2] = 32'h300;
    out_ready = 1'b1;
    step();
    chk_out("live_wins", 1'b1, 32'h300, 1'b0);
    redirect_valid = 1'b0;
    src[0] = 32'h304;
    step();
    chk_out("held_dropped", 1'b1, 32'h304, 1'b0);

    // Reset in HOLD drops the held redirect.
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    src_sel = 2'd1;
    src[1] = 32'h500;
    step();
    check("hold_mid.pending", {31'd0, pending}, 32'd1);
    redirect_valid = 1'b0;
    Reset = 1'b1;
    step();
    chk_out("reset_hold", 1'b0, 32'h0, 1'b0);
    Reset = 1'b0;
    out_ready = 1'b1;
    src[0] = 32'h4;
    step();
    chk_out("reset_hold_boot", 1'b1, 32'h0, 1'b0);
    step();
    chk_out("reset_hold_seq", 1'b1, 32'h4, 1'b0);

    // Redirect during BOOT is held and consumed by the first transfer.
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    redirect_valid = 1'b1;
    src_sel = 2'd2;
    src[2] = 32'h40;
    step();
    chk_out("boot_redir", 1'b1, 32'h0, 1'b1);
    redirect_valid = 1'b0;
    step();
    chk_out("boot_consume", 1'b1, 32'h40, 1'b0);

    // Misaligned redirect target.
    redirect_valid = 1'b1;
    src_sel = 2'd1;
    src[1] = 32'h102;
    step();
`ifdef PC_ALIGN_CHECK_EN
    exp_align = 32'h100;
    check("misalign_set", {31'd0, misalign}, 32'd1);
`else
    exp_align = 32'h102;
`endif
    chk_out("misalign_pc", 1'b1, exp_align, 1'b0);
    redirect_valid = 1'b0;
    src[0] = 32'h104;
    step();
    chk_out("misalign_next", 1'b1, 32'h104, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
    check("misalign_clr", {31'd0, misalign}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
